idu_imm_decode: RTL and testbench
=================================

Name: idu_imm_decode

Overview:
- Decode stage directly upstream of the immediate generator.
- Accepts 32-bit RV64I instructions from fetch over a valid/ready handshake and extracts the packed 20-bit immediate field, shift op, immediate width and register indices.
- Registers these fields into a 2-entry skid buffer that feeds the immediate generator and the operand muxes.
- in_ready is a registered signal, so fetch sees no combinational path from out_ready.

Parameters:
PC_W, 64, width of the program counter carried with each instruction.

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
flush  input  1  drop all buffered and incoming instructions
in_valid  input  1  fetch has an instruction
in_ready  output  1  stage can accept (registered)
in_inst  input  32  instruction word
in_pc  input  PC_W  instruction PC
out_valid  output  1  decoded entry available
out_ready  input  1  downstream accepts
out_imm  output  20  packed immediate field, unused upper bits zero
out_shift_op  output  3  000 no_shift, 001 sign_shift, 010 unsign_shift, 011 zero_fill
out_imm_width  output  2  00 20-bit, 01 13-bit, 10 12-bit, 11 reserved (never driven)
out_rd / out_rs1 / out_rs2  output  5 each  inst[11:7] / [19:15] / [24:20]
out_pc  output  PC_W  PC of the entry
out_illegal  output  1  opcode not recognised

Behaviour:
- Reset (rst high at a clock edge):
  - out_valid=0; all out_* data=0.
  - Skid entry empty; in_ready=1 from the first edge after reset.
  - Handshakes are ignored while rst is high.
- Decode rules (combinational on in_inst; result captured on accept):
  - I-type, opcodes 0010011/0000011/1100111/0011011: imm={8'b0, inst[31:20]}, sign_shift, width 10.
  - S-type, opcode 0100011: imm={8'b0, inst[31:25], inst[11:7]}, sign_shift, width 10.
  - B-type, opcode 1100011: imm={7'b0, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}, sign_shift, width 01.
  - U-type, opcodes 0110111/0010111: imm=inst[31:20+... i.e. inst[31:12], zero_fill, width 00.
  - J-type, opcode 1101111: imm={inst[31], inst[19:12], inst[20], inst[30:21]} (offset[20:1]), sign_shift, width 00. The target adder applies <<1 for J.
  - SYSTEM, opcode 1110011: imm={8'b0, inst[31:20]} (CSR address), unsign_shift, width 10.
  - R-type, opcodes 0110011/0111011: imm=0, no_shift, width 00.
  - Any other opcode: imm=0, no_shift, width 00, out_illegal=1.
- Handshake:
  - Accept when in_valid && in_ready. Output transfer when out_valid && out_ready.
  - Payload is stable while out_valid && !out_ready.
- Buffer:
  - Main register drives the outputs; the skid register holds one overflow entry.
  - Accept with main empty, or main transferring this cycle: data goes to main, and out_valid is asserted next cycle (latency 1).
  - Accept while main is held (out_valid && !out_ready): data goes to skid, and in_ready=0 next cycle.
  - Transfer while skid is full: skid moves to main; in_ready returns to 1 next cycle.
- in_ready(next) = !skid_full(next). Strict FIFO order is preserved.
- Flush (priority over everything except rst):
  - Both entries are cleared next cycle: out_valid=0, in_ready=1.
  - An instruction presented in the flush cycle is dropped.
  - out_valid does not rise until at least 2 cycles after flush.
- Simultaneous accept and transfer with skid empty: main is replaced, out_valid stays 1, no bubble.

Test Plan:
1. Accept 0xFFF00093 (addi x1,x0,-1), pc 0x80000000, out_ready=1 -> next cycle out_valid=1, out_imm=20'h00FFF, shift_op=001, width=10, rd=1, rs1=0, out_pc=0x80000000.
2. Accept 0x0020B423 (sd x2,8(x1)) -> out_imm=20'h00008, sign_shift, width=10, rs1=1, rs2=2. Then 0xFE000EE3 (beq x0,x0,-4) -> out_imm=20'h01FFC, width=01.
3. Accept 0x123452B7 (lui x5,0x12345) -> out_imm=20'h12345, shift_op=011, rd=5. Then 0x30009073 (csrrw) -> out_imm=20'h00300, shift_op=010. Then 0x00000000 -> out_illegal=1, shift_op=000, imm=0.
4. Backpressure: out_ready=0, offer A,B,C back-to-back -> A and B accepted, in_ready=0 from the cycle after B. Raise out_ready -> outputs A,B,C in order with no loss or duplication; in_ready=1 one cycle after A leaves.
5. Fill both entries, then assert flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1. None of the three instructions ever appears on the output.
6. Assert rst mid-stream with skid full -> next cycle out_valid=0, out_imm=0, in_ready=1. The first instruction accepted after rst drops appears one cycle later.

Source files
------------

// File: rtl/idu_imm_decode.sv
// Decode stage: extracts packed immediate, shift op, width and register indices into a 2-entry skid buffer.
// Latency 1 cycle from accept to out_valid; back-to-back throughput with no bubble while out_ready stays high.
// Backpressure: a held main entry diverts one overflow into skid; in_ready is registered and drops only when skid fills.
module idu_imm_decode #(
    parameter int PC_W = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [19:0]     out_imm,
    output logic [2:0]      out_shift_op,
    output logic [1:0]      out_imm_width,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [PC_W-1:0] out_pc,
    output logic            out_illegal
);

    typedef struct packed {
        logic [19:0]     imm;
        logic [2:0]      shift_op;
        logic [1:0]      imm_width;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [PC_W-1:0] pc;
        logic            illegal;
    } entry_t;

    localparam logic [2:0] SH_NONE  = 3'b000;
    localparam logic [2:0] SH_SIGN  = 3'b001;
    localparam logic [2:0] SH_UNSGN = 3'b010;
    localparam logic [2:0] SH_ZFILL = 3'b011;

    entry_t dec_dat;
    entry_t main_dat;
    entry_t skid_dat;
    logic   main_vld;
    logic   skid_vld;
    logic   in_ready_q;
    logic   acc;
    logic   xfer;

    always_comb begin
        dec_dat           = '0;
        dec_dat.rd        = in_inst[11:7];
        dec_dat.rs1       = in_inst[19:15];
        dec_dat.rs2       = in_inst[24:20];
        dec_dat.pc        = in_pc;
        case (in_inst[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b0011011: begin
                dec_dat.imm       = {8'b0, in_inst[31:20]};
                dec_dat.shift_op  = SH_SIGN;
                dec_dat.imm_width = 2'b10;
            end
            7'b0100011: begin
                dec_dat.imm       = {8'b0, in_inst[31:25], in_inst[11:7]};
                dec_dat.shift_op  = SH_SIGN;
                dec_dat.imm_width = 2'b10;
            end
            7'b1100011: begin
                dec_dat.imm       = {7'b0, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
                dec_dat.shift_op  = SH_SIGN;
                dec_dat.imm_width = 2'b01;
            end
            7'b0110111, 7'b0010111: begin
                dec_dat.imm       = in_inst[31:12];
                dec_dat.shift_op  = SH_ZFILL;
            end
            // J offset is carried as bits [20:1]; the target adder restores the <<1.
            7'b1101111: begin
                dec_dat.imm       = {in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21]};
                dec_dat.shift_op  = SH_SIGN;
            end
            7'b1110011: begin
                dec_dat.imm       = {8'b0, in_inst[31:20]};
                dec_dat.shift_op  = SH_UNSGN;
                dec_dat.imm_width = 2'b10;
            end
            7'b0110011, 7'b0111011: begin
                dec_dat.shift_op  = SH_NONE;
            end
            default: begin
                dec_dat.illegal   = 1'b1;
            end
        endcase
    end

    assign acc  = in_valid && in_ready_q;
    assign xfer = main_vld && out_ready;

    // in_ready_q always mirrors !skid_vld, so an accept can never coincide with a full skid.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_vld   <= 1'b0;
            skid_vld   <= 1'b0;
            in_ready_q <= 1'b1;
            main_dat   <= '0;
            skid_dat   <= '0;
        end else if (flush) begin
            main_vld   <= 1'b0;
            skid_vld   <= 1'b0;
            in_ready_q <= 1'b1;
        end else if (skid_vld) begin
            if (xfer) begin
                main_dat   <= skid_dat;
                skid_vld   <= 1'b0;
                in_ready_q <= 1'b1;
            end
        end else if (acc && (!main_vld || xfer)) begin
            main_dat <= dec_dat;
            main_vld <= 1'b1;
        end else if (acc) begin
            skid_dat   <= dec_dat;
            skid_vld   <= 1'b1;
            in_ready_q <= 1'b0;
        end else if (xfer) begin
            main_vld <= 1'b0;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = main_vld;
    assign out_imm       = main_dat.imm;
    assign out_shift_op  = main_dat.shift_op;
    assign out_imm_width = main_dat.imm_width;
    assign out_rd        = main_dat.rd;
    assign out_rs1       = main_dat.rs1;
    assign out_rs2       = main_dat.rs2;
    assign out_pc        = main_dat.pc;
    assign out_illegal   = main_dat.illegal;

endmodule

// File: tb/tb_idu_imm_decode.sv
// Scoreboard bench for idu_imm_decode: arithmetic immediate model, queue of expected entries, negedge monitor.
module tb_idu_imm_decode;

    typedef struct packed {
        logic [19:0] imm;
        logic [2:0]  shift_op;
        logic [1:0]  imm_width;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] pc;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_imm;
    logic [2:0]  out_shift_op;
    logic [1:0]  out_imm_width;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [63:0] out_pc;
    logic        out_illegal;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    logic rst_seen = 1'b0;

    idu_imm_decode #(.PC_W(64)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_shift_op(out_shift_op), .out_imm_width(out_imm_width),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_pc(out_pc), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // Reference: compute the architectural offset as an integer, then keep the bits the stage forwards.
    function automatic exp_t model(input logic [31:0] i, input logic [63:0] pc);
        exp_t e;
        int   off;
        e     = '0;
        e.rd  = i[11:7];
        e.rs1 = i[19:15];
        e.rs2 = i[24:20];
        e.pc  = pc;
        case (i[6:0])
            7'h13, 7'h03, 7'h67, 7'h1b: begin
                off = int'($signed(i[31:20]));
                e.imm = 20'(off & 32'hFFF); e.shift_op = 3'd1; e.imm_width = 2'd2;
            end
            7'h23: begin
                off = int'($signed(i[31:25])) * 32 + int'(i[11:7]);
                e.imm = 20'(off & 32'hFFF); e.shift_op = 3'd1; e.imm_width = 2'd2;
            end
            7'h63: begin
                off = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
                e.imm = 20'(off & 32'h1FFF); e.shift_op = 3'd1; e.imm_width = 2'd1;
            end
            7'h37, 7'h17: begin
                e.imm = 20'(i >> 12); e.shift_op = 3'd3;
            end
            7'h6f: begin
                off = (i[31] ? -(1 << 20) : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
                e.imm = 20'((off >> 1) & 32'hFFFFF); e.shift_op = 3'd1;
            end
            7'h73: begin
                e.imm = 20'(i >> 20); e.shift_op = 3'd2; e.imm_width = 2'd2;
            end
            7'h33, 7'h3b: ;
            default: e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  ops [12] = '{7'h13, 7'h03, 7'h67, 7'h1b, 7'h23, 7'h63,
                                  7'h37, 7'h17, 7'h6f, 7'h73, 7'h33, 7'h3b};
        r = $urandom;
        if ($urandom_range(0, 5) != 0)
            r[6:0] = ops[$urandom_range(0, 11)];
        return r;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t act;
        exp_t e;
        act = '{out_imm, out_shift_op, out_imm_width, out_rd, out_rs1, out_rs2, out_pc, out_illegal};
        if (rst_seen) begin
            n_cmp++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || act !== '0) begin
                n_bad++;
                $display("FAIL reset_state: got valid=%b ready=%b data=%h, want valid=0 ready=1 data=0",
                         out_valid, in_ready, act);
            end
        end
        rst_seen = rst;
        if (rst) begin
            sb.delete();
        end else begin
            n_cmp++;
            if (in_ready !== (sb.size() < 2)) begin
                n_bad++;
                $display("FAIL in_ready: got %b, want %b (entries %0d)", in_ready, sb.size() < 2, sb.size());
            end
            n_cmp++;
            if (out_valid !== (sb.size() != 0)) begin
                n_bad++;
                $display("FAIL out_valid: got %b, want %b (entries %0d)", out_valid, sb.size() != 0, sb.size());
            end
            if (flush) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready && sb.size() != 0) begin
                    e = sb.pop_front();
                    n_cmp++;
                    if (act !== e) begin
                        n_bad++;
                        $display("FAIL payload: got imm=%h sh=%b w=%b rd=%0d rs1=%0d rs2=%0d pc=%h ill=%b, want imm=%h sh=%b w=%b rd=%0d rs1=%0d rs2=%0d pc=%h ill=%b",
                                 act.imm, act.shift_op, act.imm_width, act.rd, act.rs1, act.rs2, act.pc, act.illegal,
                                 e.imm, e.shift_op, e.imm_width, e.rd, e.rs1, e.rs2, e.pc, e.illegal);
                    end
                end
                if (in_valid && in_ready)
                    sb.push_back(model(in_inst, in_pc));
            end
        end
    end

    task automatic send(input logic [31:0] inst, input logic [63:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (!in_ready) begin
            $display("FAIL send_timeout: in_ready stuck at %b, want 1 within 100 cycles", in_ready);
            $fatal(1, "accept timeout");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_inst = '0; in_pc = '0;
        idle(3);
        rst = 1'b0;

        send(32'hFFF00093, 64'h8000_0000);
        send(32'h0020B423, 64'h8000_0004);
        send(32'hFE000EE3, 64'h8000_0008);
        send(32'h123452B7, 64'h8000_000C);
        send(32'h30009073, 64'h8000_0010);
        send(32'h00000000, 64'h8000_0014);
        send(32'h0040006F, 64'h8000_0018);
        idle(3);

        // Backpressure: A to main, B to skid, C waits until out_ready returns.
        out_ready = 1'b0;
        send(32'h00100113, 64'h100);
        send(32'h00200193, 64'h104);
        fork
            send(32'h00300213, 64'h108);
            begin idle(4); out_ready = 1'b1; end
        join
        idle(5);

        // Flush with both entries full and a new instruction offered.
        out_ready = 1'b0;
        send(32'h00400293, 64'h200);
        send(32'h00500313, 64'h204);
        in_valid = 1'b1; in_inst = 32'h00600393; in_pc = 64'h208; flush = 1'b1;
        idle(1);
        flush = 1'b0; in_valid = 1'b0;
        idle(2);
        out_ready = 1'b1;
        idle(3);

        // Reset mid-stream with skid full.
        out_ready = 1'b0;
        send(32'h00700413, 64'h300);
        send(32'h00800493, 64'h304);
        rst = 1'b1; in_valid = 1'b1; in_inst = 32'h00900513; in_pc = 64'h308;
        idle(1);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        send(32'h00A00593, 64'h30C);
        idle(3);

        repeat (3000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_inst   = rand_inst();
            in_pc     = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            idle(1);
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
